// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase scheduler.
// Light codes, phase states and the round-robin next-approach helper.
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    typedef enum logic [2:0] {
        G_MIN   = 3'd0,
        G_EXT   = 3'd1,
        YELLOW  = 3'd2,
        ALL_RED = 3'd3,
        WALK    = 3'd4
    } phase_t;

    // First set request scanning cur+1, cur+2, ... modulo n.
    // Scanning to cur+n lands on cur itself, so with no
    // request pending the current approach is kept.
    function automatic logic [2:0] rr_next(
        input logic [7:0]  req,
        input logic [2:0]  cur,
        input int unsigned n
    );
        logic [2:0] nxt;
        logic       hit;
        logic [2:0] idx;
        nxt = cur;
        hit = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            if (k <= n) begin
                idx = 3'((32'(cur) + k) % n);
                if (!hit && req[idx]) begin
                    nxt = idx;
                    hit = 1'b1;
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by every timed phase.
// Ports: clk, reset (async high), load, load_val -> value, done (value==0).
module phase_timer #(
    parameter int             TW      = 8,
    parameter logic [TW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] value,
    output logic          done
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - TW'(1);
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin green scheduler for N_APPR approaches; approach 0 is the rest road.
// Ports: clk, reset (async high), sensor[N] -> lights[2N], cur_phase, phase_st;
// with PED_WALK_EN defined also ped_req -> ped_walk (walk phase after all-red).
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_APPR    = 4,
    parameter int TW        = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALL_RED_T = 1,
    parameter int WALK_T    = 6,
    localparam int PW       = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_APPR-1:0] sensor,
    output logic [2*N_APPR-1:0] lights,
    output logic [PW-1:0]     cur_phase,
    output logic [2:0]        phase_st
`ifdef PED_WALK_EN
    ,
    input  logic              ped_req,
    output logic              ped_walk
`endif
);

    localparam logic [TW-1:0] T_MIN  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_AR   = TW'(ALL_RED_T - 1);
    localparam logic [TW-1:0] T_WALK = TW'(WALK_T - 1);
    localparam logic [2*N_APPR-1:0] LIGHTS_RST = (2*N_APPR)'(LIGHT_GREEN);

    phase_t              state, state_n;
    logic [PW-1:0]       cur, cur_n;
    logic [N_APPR-1:0]   req, req_n;
    logic [TW-1:0]       gcnt, gcnt_n;
    logic [2*N_APPR-1:0] lights_n;
    logic                load;
    logic [TW-1:0]       load_val;
    logic [TW-1:0]       tval;
    logic                tdone;
    logic                green, conflict, gexit, entering;
`ifdef PED_WALK_EN
    logic                ped_lat, ped_lat_n;
    logic                ped_served, ped_served_n;
    logic                ped_walk_n;
`endif

    phase_timer #(
        .TW      (TW),
        .RST_VAL (T_MIN)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .value    (tval),
        .done     (tdone)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= G_MIN;
            cur    <= '0;
            req    <= '0;
            gcnt   <= '0;
            lights <= LIGHTS_RST;
        end else begin
            state  <= state_n;
            cur    <= cur_n;
            req    <= req_n;
            gcnt   <= gcnt_n;
            lights <= lights_n;
        end
    end

`ifdef PED_WALK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_lat    <= 1'b0;
            ped_served <= 1'b0;
            ped_walk   <= 1'b0;
        end else begin
            ped_lat    <= ped_lat_n;
            ped_served <= ped_served_n;
            ped_walk   <= ped_walk_n;
        end
    end
`endif

    always_comb begin
        state_n  = state;
        cur_n    = cur;
        green    = (state == G_MIN) || (state == G_EXT);
        conflict = |req;
`ifdef PED_WALK_EN
        conflict = conflict | ped_lat;
`endif
        // gcnt counts green cycles already completed, so the
        // current cycle is green cycle gcnt+1.
        gexit = conflict && (!sensor[cur] || (gcnt >= T_MAX));

        unique case (state)
            G_MIN: begin
                // The extension check is folded into the last
                // minimum-green cycle so yellow follows without a gap.
                if (tdone) begin
                    state_n = gexit ? YELLOW : G_EXT;
                end
            end
            G_EXT: begin
                if (gexit) begin
                    state_n = YELLOW;
                end
            end
            YELLOW: begin
                if (tdone) begin
                    state_n = ALL_RED;
                end
            end
            ALL_RED: begin
                if (tdone) begin
`ifdef PED_WALK_EN
                    if (ped_lat && !ped_served) begin
                        state_n = WALK;
                    end else begin
                        state_n = G_MIN;
                        cur_n   = PW'(rr_next(8'(req), 3'(cur), N_APPR));
                    end
`else
                    state_n = G_MIN;
                    cur_n   = PW'(rr_next(8'(req), 3'(cur), N_APPR));
`endif
                end
            end
            WALK: begin
                if (tdone) begin
                    state_n = ALL_RED;
                end
            end
            default: begin
                state_n = G_MIN;
            end
        endcase

        entering = (state_n == G_MIN) && (state != G_MIN);
        load     = (state_n != state);

        unique case (state_n)
            G_MIN:   load_val = T_MIN;
            YELLOW:  load_val = T_YEL;
            ALL_RED: load_val = T_AR;
            WALK:    load_val = T_WALK;
            default: load_val = '0;
        endcase

        if (entering) begin
            gcnt_n = '0;
        end else if (green && (gcnt != '1)) begin
            gcnt_n = gcnt + TW'(1);
        end else begin
            gcnt_n = gcnt;
        end

        req_n    = req;
        lights_n = '0;
        for (int i = 0; i < N_APPR; i++) begin
            if (entering && (cur_n == PW'(i))) begin
                req_n[i] = 1'b0;
            end else if (sensor[i] && !(green && (cur == PW'(i)))) begin
                req_n[i] = 1'b1;
            end
            if (cur_n == PW'(i)) begin
                if ((state_n == G_MIN) || (state_n == G_EXT)) begin
                    lights_n[2*i +: 2] = LIGHT_GREEN;
                end else if (state_n == YELLOW) begin
                    lights_n[2*i +: 2] = LIGHT_YELLOW;
                end
            end
        end

`ifdef PED_WALK_EN
        ped_walk_n = (state_n == WALK);
        if ((state_n == WALK) && (state != WALK)) begin
            ped_lat_n = 1'b0;
        end else begin
            ped_lat_n = ped_lat | ped_req;
        end
        // Blocks a second walk at the all-red that follows a walk.
        if (entering) begin
            ped_served_n = 1'b0;
        end else if ((state == WALK) && (state_n == ALL_RED)) begin
            ped_served_n = 1'b1;
        end else begin
            ped_served_n = ped_served;
        end
`endif
    end

    assign cur_phase = cur;
    assign phase_st  = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler (N_APPR=4).
// Stimulus pushes cycle-tagged expectations; a negedge monitor pops and compares.
module tb_intersection_phase_scheduler;

    localparam logic [2:0] S_GMIN = 3'd0;
    localparam logic [2:0] S_GEXT = 3'd1;
    localparam logic [2:0] S_YEL  = 3'd2;
    localparam logic [2:0] S_AR   = 3'd3;
    localparam logic [2:0] S_WALK = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sensor = 4'b0000;
    logic [7:0] lights;
    logic [1:0] cur_phase;
    logic [2:0] phase_st;
`ifdef PED_WALK_EN
    logic       ped_req = 1'b0;
    logic       ped_walk;
`endif

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] lt;
        logic [1:0] cp;
        logic [2:0] st;
        logic       pw;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   ns   = 0;
    int   base = 0;
    int   nid  = 0;
    int   nvec = 0;
    int   nerr = 0;

    intersection_phase_scheduler #(
        .N_APPR    (4),
        .TW        (8),
        .MIN_GREEN (4),
        .MAX_GREEN (10),
        .YELLOW_T  (2),
        .ALL_RED_T (1),
        .WALK_T    (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor    (sensor),
        .lights    (lights),
        .cur_phase (cur_phase),
        .phase_st  (phase_st)
`ifdef PED_WALK_EN
        ,
        .ped_req   (ped_req),
        .ped_walk  (ped_walk)
`endif
    );

    always #5 clk = ~clk;

    task automatic push_abs(input int c, input logic [7:0] lt,
                            input logic [1:0] cp, input logic [2:0] st,
                            input logic pw);
        exp_t x;
        x.cyc = c;
        x.id  = nid;
        x.lt  = lt;
        x.cp  = cp;
        x.st  = st;
        x.pw  = pw;
        nid++;
        q.push_back(x);
    endtask

    task automatic push(input int k, input logic [7:0] lt,
                        input logic [1:0] cp, input logic [2:0] st,
                        input logic pw);
        push_abs(base + k, lt, cp, st, pw);
    endtask

    task automatic at(input int k);
        while (ns < base + k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        sensor = 4'b0000;
`ifdef PED_WALK_EN
        ped_req = 1'b0;
`endif
        push_abs(ns, 8'h02, 2'd0, S_GMIN, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base  = ns;
    endtask

    always @(negedge clk) begin
        #2;
        while (q.size() > 0 && q[0].cyc <= ns) begin
            e = q.pop_front();
            nvec++;
            if (e.cyc < ns) begin
                nerr++;
                $display("FAIL vec%0d missed: sample %0d, required %0d",
                         e.id, ns, e.cyc);
            end else if (lights !== e.lt || cur_phase !== e.cp ||
                         phase_st !== e.st
`ifdef PED_WALK_EN
                         || ped_walk !== e.pw
`endif
                         ) begin
                nerr++;
                $display("FAIL vec%0d cyc%0d: got lights=%b cur=%0d st=%0d, want lights=%b cur=%0d st=%0d pw=%b",
                         e.id, e.cyc - base, lights, cur_phase, phase_st,
                         e.lt, e.cp, e.st, e.pw);
            end
        end
        ns++;
    end

    initial begin
        // idle: rest in green on approach 0
        do_reset();
        push(0, 8'h02, 2'd0, S_GMIN, 1'b0);
        push(3, 8'h02, 2'd0, S_GMIN, 1'b0);
        push(4, 8'h02, 2'd0, S_GEXT, 1'b0);
        for (int k = 10; k < 50; k += 10)
            push(k, 8'h02, 2'd0, S_GEXT, 1'b0);
        push(49, 8'h02, 2'd0, S_GEXT, 1'b0);
        at(50);

        // single request on approach 2
        do_reset();
        push(3, 8'h02, 2'd0, S_GMIN, 1'b0);
        push(4, 8'h01, 2'd0, S_YEL, 1'b0);
        push(5, 8'h01, 2'd0, S_YEL, 1'b0);
        push(6, 8'h00, 2'd0, S_AR, 1'b0);
        push(7, 8'h20, 2'd2, S_GMIN, 1'b0);
        push(11, 8'h20, 2'd2, S_GEXT, 1'b0);
        at(1); sensor = 4'b0100;
        at(2); sensor = 4'b0000;
        at(12);

        // max green with sensor[0] held
        do_reset();
        sensor = 4'b0001;
        push(4, 8'h02, 2'd0, S_GEXT, 1'b0);
        push(9, 8'h02, 2'd0, S_GEXT, 1'b0);
        push(10, 8'h01, 2'd0, S_YEL, 1'b0);
        push(12, 8'h00, 2'd0, S_AR, 1'b0);
        push(13, 8'h08, 2'd1, S_GMIN, 1'b0);
        push(16, 8'h08, 2'd1, S_GMIN, 1'b0);
        push(17, 8'h04, 2'd1, S_YEL, 1'b0);
        at(2); sensor = 4'b0011;
        at(3); sensor = 4'b0001;
        at(11); sensor = 4'b0000;
        at(18);

        // wrap-around: 3 before 1
        do_reset();
        push(7, 8'h20, 2'd2, S_GMIN, 1'b0);
        push(11, 8'h10, 2'd2, S_YEL, 1'b0);
        push(13, 8'h00, 2'd2, S_AR, 1'b0);
        push(14, 8'h80, 2'd3, S_GMIN, 1'b0);
        push(17, 8'h80, 2'd3, S_GMIN, 1'b0);
        push(18, 8'h40, 2'd3, S_YEL, 1'b0);
        push(20, 8'h00, 2'd3, S_AR, 1'b0);
        push(21, 8'h08, 2'd1, S_GMIN, 1'b0);
        push(24, 8'h08, 2'd1, S_GMIN, 1'b0);
        push(25, 8'h08, 2'd1, S_GEXT, 1'b0);
        at(1); sensor = 4'b0100;
        at(2); sensor = 4'b0000;
        at(8); sensor = 4'b1010;
        at(9); sensor = 4'b0000;
        at(26);

        // reset during yellow of approach 2, pending reqs dropped
        do_reset();
        push(11, 8'h10, 2'd2, S_YEL, 1'b0);
        at(1); sensor = 4'b0100;
        at(2); sensor = 4'b0000;
        at(8); sensor = 4'b1000;
        at(9); sensor = 4'b0000;
        at(11); sensor = 4'b0010;
        at(12);
        sensor = 4'b0000;
        reset  = 1'b1;
        push_abs(ns, 8'h02, 2'd0, S_GMIN, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base  = ns;
        push(0, 8'h02, 2'd0, S_GMIN, 1'b0);
        push(4, 8'h02, 2'd0, S_GEXT, 1'b0);
        push(6, 8'h02, 2'd0, S_GEXT, 1'b0);
        at(8);

`ifdef PED_WALK_EN
        // pedestrian walk, no vehicle requests
        do_reset();
        push(4, 8'h01, 2'd0, S_YEL, 1'b0);
        push(6, 8'h00, 2'd0, S_AR, 1'b0);
        push(7, 8'h00, 2'd0, S_WALK, 1'b1);
        push(12, 8'h00, 2'd0, S_WALK, 1'b1);
        push(13, 8'h00, 2'd0, S_AR, 1'b0);
        push(14, 8'h02, 2'd0, S_GMIN, 1'b0);
        at(1); ped_req = 1'b1;
        at(2); ped_req = 1'b0;
        at(16);
`endif

        repeat (3) @(negedge clk);
        #4;
        while (q.size() > 0) begin
            e = q.pop_front();
            nvec++;
            nerr++;
            $display("FAIL vec%0d never sampled: sample %0d, required %0d",
                     e.id, ns, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
